uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter: DIV_WIDTH, default 16, width of the runtime baud divisor.
REQ-002 Parameter: FIFO_DEPTH, default 8, transmit FIFO entries; power of two, >= 2.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: wr_en  in  1  write strobe; wr_data is pushed to the FIFO when not full.
REQ-006 Port: wr_data  in  8  character to send; LSB first; bits above the selected data width are ignored.
REQ-007 Port: data_bits  in  2  data width: 00=5, 01=6, 10=7, 11=8.
REQ-008 Port: parity_mode  in  2  parity: 00=none, 01=even, 10=odd, 11=none.
REQ-009 Port: stop2  in  1  0 = one stop bit, 1 = two stop bits.
REQ-010 Port: baud_div  in  DIV_WIDTH  bit period in clocks, minus one.
REQ-011 Port: txd  out  1  registered serial line; idle high.
REQ-012 Port: busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
REQ-013 Port: full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-014 Port: level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 Port: overflow  out  1  one-cycle pulse when a write is dropped.

Function
REQ-016 The FIFO shall push on wr_en && !full; a write while full shall be dropped and shall pulse overflow on the next cycle, even if a pop occurs on the same edge.
REQ-017 A simultaneous push and pop shall leave level unchanged; pointers shall wrap modulo FIFO_DEPTH.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-019 IDLE with FIFO non-empty: on the next edge, pop the head, latch the character plus data_bits, parity_mode, stop2 and baud_div, and enter START.
REQ-020 Latched configuration shall govern the whole frame; input changes mid-frame shall take effect only from the next frame.
REQ-021 Each of START, each DATA bit, PARITY, STOP1 and STOP2 shall last exactly baud_div+1 clocks, timed by a down-counter reloaded on entry.
REQ-022 txd shall be 0 in START, data bit i (i = 0 to n-1, LSB first) in DATA, the parity bit in PARITY, and 1 in STOP1, STOP2 and IDLE.
REQ-023 Even parity bit = XOR of the n data bits; odd parity bit = its inverse; PARITY shall be skipped when parity is none.
REQ-024 STOP2 shall be visited only when stop2 was latched as 1.
REQ-025 At the end of the last stop period, the FSM shall enter START directly if the FIFO is non-empty (no idle gap), otherwise IDLE.
REQ-026 Frame length shall be (1 + n + p + s) * (baud_div+1) clocks, where p = 0 or 1 and s = 1 or 2.
REQ-027 Latency: a write accepted at edge E into an empty FIFO while in IDLE shall drive txd low from edge E+1.
REQ-028 baud_div = 0 shall give one clock per bit with no dropped or extra bits.
REQ-029 txd shall be registered and glitch-free.

Reset
REQ-030 While rst is high at a clock edge: FSM returns to IDLE; FIFO is flushed (level = 0); txd = 1; busy, full and overflow = 0; the bit counter clears.
REQ-031 Reset mid-frame shall abort the frame immediately; txd shall be 1 at the edge following reset assertion, and the aborted character shall not be resent.

Verification
REQ-032 8N1, baud_div = 3, write 0x55 once -> txd = 0,1,0,1,0,1,0,1,0,1, each value held 4 clocks (40 clocks total); busy falls at the end of the stop bit.
REQ-033 7E2, baud_div = 1, write 0x41 -> start 0, data 1,0,0,0,0,0,1, parity 0, stop 1,1, each held 2 clocks (22 clocks).
REQ-034 5O1, baud_div = 0, write 0xFF -> start 0, data 1,1,1,1,1, parity 0, stop 1 (8 clocks); bits 7:5 do not appear.
REQ-035 FIFO_DEPTH = 8, baud_div = 100, ten writes on consecutive edges -> 9 accepted (the first pops at once); the 10th raises overflow for one cycle; full = 1, level = 8; all 9 frames are sent back-to-back with no idle gap.
REQ-036 rst pulsed in the middle of DATA with 3 entries queued -> txd = 1 next edge; level = 0; busy = 0; no further frames are sent.
REQ-037 Change data_bits and parity_mode during a frame -> the current frame is unchanged; the next queued frame uses the new settings.

Source files
------------

// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
//   Buffered UART transmitter with per-frame runtime configuration.
//   Characters written into a small FIFO are serialised as
//   start / 5..8 data bits (LSB first) / optional parity / 1 or 2 stop bits.
//   The frame format and the bit period are captured from the inputs when a
//   character is popped, so changing them mid-frame only affects later frames.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   wr_en        write strobe (accepted when not full)
//   wr_data      character to send (bits above the data width are ignored)
//   data_bits    00=5, 01=6, 10=7, 11=8 data bits
//   parity_mode  00/11=none, 01=even, 10=odd
//   stop2        0 = one stop bit, 1 = two stop bits
//   baud_div     bit period in clocks minus one
//   txd          registered serial output, idle high
//   busy         FSM active or FIFO non-empty
//   full         FIFO holds FIFO_DEPTH entries
//   level        FIFO occupancy
//   overflow     one-cycle pulse after a write was dropped
// ---------------------------------------------------------------------------
module uart_tx_param #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic [1:0]                  data_bits,
    input  logic [1:0]                  parity_mode,
    input  logic                        stop2,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    output logic                        txd,
    output logic                        busy,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    // Parity over the active data bits only; odd mode is the inverse of even.
    function automatic logic parity_bit(input logic [7:0] c,
                                        input logic [1:0] db,
                                        input logic [1:0] pm);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - db);
        return (^(c & mask)) ^ pm[1];
    endfunction

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q;
    logic          empty, push, pop;

    // Frame state and latched per-frame configuration
    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             char_q;
    logic [1:0]             db_q, pm_q;
    logic                   s2_q;
    logic [DIV_WIDTH-1:0]   div_q;
    logic                   txd_q, txd_d;
    logic                   tick, last, load, par_en;

    assign empty    = (level_q == '0);
    assign full     = (level_q == (AW+1)'(FIFO_DEPTH));
    assign push     = wr_en && !full;
    assign pop      = load;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != S_IDLE) || !empty;
    assign txd      = txd_q;

    assign tick   = (cnt_q == '0);
    assign par_en = pm_q[0] ^ pm_q[1];

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        last    = 1'b0;
        load    = 1'b0;
        // Every non-idle state counts down and reloads when its period ends.
        cnt_d   = tick ? div_q : cnt_q - DIV_WIDTH'(1);

        unique case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    // Last data bit index is n-1 = 4 + data_bits.
                    if (bit_q == {1'b1, db_q}) begin
                        state_d = par_en ? S_PARITY : S_STOP1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) state_d = S_STOP1;
            end
            S_STOP1: begin
                if (tick) begin
                    if (s2_q) state_d = S_STOP2;
                    else      last    = 1'b1;
                end
            end
            S_STOP2: begin
                if (tick) last = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (last) state_d = S_IDLE;

        // Start a new frame from idle, or chain directly after the last stop bit.
        if ((state_q == S_IDLE || last) && !empty) begin
            load    = 1'b1;
            state_d = S_START;
            cnt_d   = baud_div;
            bit_d   = 3'd0;
        end
    end

    // txd is derived from the next state so the line changes exactly on the
    // edge that enters each bit period.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = char_q[bit_d];
            S_PARITY: txd_d = parity_bit(char_q, db_q, pm_q);
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            txd_q      <= 1'b1;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            txd_q      <= txd_d;
            level_q    <= level_d;
            overflow_q <= wr_en && full;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    // Storage and latched frame contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
        if (load) begin
            char_q <= mem_q[rptr_q];
            db_q   <= data_bits;
            pm_q   <= parity_mode;
            s2_q   <= stop2;
            div_q  <= baud_div;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [1:0]  data_bits = 2'b11;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop2 = 1'b0;
    logic [15:0] baud_div = 16'd0;
    logic        txd, busy, full, overflow;
    logic [3:0]  level;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_busy = 1'b0;

    typedef struct {
        logic [7:0]  ch;
        logic [1:0]  db;
        logic [1:0]  pm;
        logic        s2;
        logic [15:0] div;
        bit          b2b;
    } ent_t;

    ent_t sb_q[$];

    uart_tx_param #(.DIV_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .data_bits(data_bits), .parity_mode(parity_mode), .stop2(stop2),
        .baud_div(baud_div), .txd(txd), .busy(busy), .full(full),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame built from the line format rules: start 0, n data bits
    // LSB first, optional parity, 1 or 2 stop ones.
    function automatic int build(input ent_t e, output logic [11:0] b);
        int n, k;
        logic par;
        b   = '1;
        n   = 5 + int'(e.db);
        k   = 0;
        par = 1'b0;
        b[k] = 1'b0; k++;
        for (int i = 0; i < n; i++) begin
            b[k] = e.ch[i];
            par  = par ^ e.ch[i];
            k++;
        end
        if (e.pm == 2'b01) begin b[k] = par;  k++; end
        if (e.pm == 2'b10) begin b[k] = ~par; k++; end
        b[k] = 1'b1; k++;
        if (e.s2) begin b[k] = 1'b1; k++; end
        return k;
    endfunction

    // Monitor: pops an expected frame and checks every sample of every bit.
    initial begin : monitor
        ent_t        e;
        logic [11:0] fb;
        int          len, w, nbad;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                mon_busy = 1'b1;
                len = build(e, fb);
                if (e.b2b) check_int("b2b_no_gap txd", int'(txd), 0);
                w = 0;
                while (txd !== 1'b0 && w < 300) begin
                    @(negedge clk);
                    w++;
                end
                check_int("start_bit_within_bound", int'(w < 300), 1);
                if (w < 300) begin
                    for (int b = 0; b < len; b++) begin
                        nbad = 0;
                        for (int k = 0; k <= int'(e.div); k++) begin
                            if (!(b == 0 && k == 0)) @(negedge clk);
                            if (txd !== fb[b]) nbad++;
                        end
                        check_int($sformatf("frame ch=%02h fmt=%0d/%0d/%0d div=%0d bit%0d bad_samples",
                                            e.ch, e.db, e.pm, e.s2, e.div, b), nbad, 0);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic put(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pm,
                       input logic s2, input logic [15:0] div, input bit b2b, input bit sb);
        ent_t e;
        if (sb) begin
            e.ch = d; e.db = db; e.pm = pm; e.s2 = s2; e.div = div; e.b2b = b2b;
            sb_q.push_back(e);
        end
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic [1:0] pm,
                           input logic s2, input logic [15:0] div);
        data_bits = db; parity_mode = pm; stop2 = s2; baud_div = div;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((sb_q.size() != 0 || mon_busy || busy) && c < 20000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_int("idle_within_bound", int'(c < 20000), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int cnt, lows, nb;
        logic [1:0]  rdb, rpm;
        logic        rs2;
        logic [15:0] rdiv;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset txd", int'(txd), 1);
        check_int("reset busy", int'(busy), 0);
        check_int("reset full", int'(full), 0);
        check_int("reset level", int'(level), 0);
        check_int("reset overflow", int'(overflow), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 8N1, div 3, 0x55: latency and 40-clock frame
        set_cfg(2'b11, 2'b00, 1'b0, 16'd3);
        put(8'h55, 2'b11, 2'b00, 1'b0, 16'd3, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_int("latency txd low at E+1", int'(txd), 0);
        cnt = 0;
        while (busy && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_int("8N1 frame clocks until busy falls", cnt, 40);
        wait_idle();

        // 7E2, div 1, 0x41
        set_cfg(2'b10, 2'b01, 1'b1, 16'd1);
        put(8'h41, 2'b10, 2'b01, 1'b1, 16'd1, 1'b0, 1'b1);
        wait_idle();

        // 5O1, div 0, 0xFF
        set_cfg(2'b00, 2'b10, 1'b0, 16'd0);
        put(8'hFF, 2'b00, 2'b10, 1'b0, 16'd0, 1'b0, 1'b1);
        wait_idle();

        // Ten writes on consecutive edges with a long bit period
        set_cfg(2'b11, 2'b00, 1'b0, 16'd100);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) check_int("overflow before drop", int'(overflow), 0);
            put(8'($urandom_range(0, 255)), 2'b11, 2'b00, 1'b0, 16'd100, i != 0, i < 9);
        end
        check_int("overflow pulse", int'(overflow), 1);
        check_int("full after burst", int'(full), 1);
        check_int("level after burst", int'(level), 8);
        @(posedge clk);
        #1;
        check_int("overflow one cycle only", int'(overflow), 0);
        check_int("level holds during frame", int'(level), 8);
        wait_idle();

        // Config change mid-frame: A keeps 8N1 div 2, B picks up 6O2 div 1
        set_cfg(2'b11, 2'b00, 1'b0, 16'd2);
        put(8'hA7, 2'b11, 2'b00, 1'b0, 16'd2, 1'b0, 1'b1);
        put(8'h3C, 2'b01, 2'b10, 1'b1, 16'd1, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        set_cfg(2'b01, 2'b10, 1'b1, 16'd1);
        wait_idle();

        // Randomised batches
        for (int r = 0; r < 20; r++) begin
            rdb  = 2'($urandom_range(0, 3));
            rpm  = 2'($urandom_range(0, 3));
            rs2  = 1'($urandom_range(0, 1));
            rdiv = 16'($urandom_range(0, 3));
            set_cfg(rdb, rpm, rs2, rdiv);
            nb = $urandom_range(1, 4);
            for (int i = 0; i < nb; i++)
                put(8'($urandom_range(0, 255)), rdb, rpm, rs2, rdiv, i != 0, 1'b1);
            wait_idle();
        end

        // Reset mid-DATA with three characters queued
        set_cfg(2'b11, 2'b00, 1'b0, 16'd3);
        for (int i = 0; i < 4; i++)
            put(8'h00, 2'b11, 2'b00, 1'b0, 16'd3, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check_int("queued before reset", int'(level), 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_int("abort txd high", int'(txd), 1);
        check_int("abort level", int'(level), 0);
        check_int("abort busy", int'(busy), 0);
        check_int("abort full", int'(full), 0);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check_int("no frame after reset (low samples)", lows, 0);
        check_int("busy stays low after reset", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
